// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port synchronous memory between fetch and load/store
// Data has priority; a streak counter bounds how long a pending fetch can be starved.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LAT     = 2,
   parameter int MAX_DSTREAK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                flush,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                d_stall,
   output logic                mem_cs,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_streak;
   logic [2:0]        r_cnt;
   logic              r_drop;
   logic              r_gnt_d;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;

   logic w_idle;
   logic w_streak_full;
   logic w_grant_d;
   logic w_grant_i;
   logic w_grant;

   assign w_idle        = (r_state == S_IDLE);
   assign w_streak_full = (r_streak == 4'(MAX_DSTREAK));
   assign w_grant_d     = w_idle & d_req & ~(if_req & w_streak_full);
   // A flushed fetch is never granted in the flush cycle; the address is stale.
   assign w_grant_i     = w_idle & ~w_grant_d & if_req & ~flush;
   assign w_grant       = w_grant_d | w_grant_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_next = S_ISSUE;
         S_ISSUE: begin
            if (r_we || MEM_LAT == 1) w_next = S_DONE;
            else                      w_next = S_WAIT;
         end
         S_WAIT:  if (r_cnt == 3'd1) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_cs   = 1'b0;
      mem_we   = 1'b0;
      d_valid  = 1'b0;
      if_valid = 1'b0;
      d_rdata  = '0;
      if_rdata = '0;
      case (r_state)
         S_ISSUE: begin
            mem_cs = 1'b1;
            mem_we = r_we;
         end
         S_DONE: begin
            d_valid  = r_gnt_d;
            if_valid = ~r_gnt_d & ~r_drop & ~flush;
            if (r_gnt_d && !r_we) d_rdata  = mem_rdata;
            if (!r_gnt_d && !r_drop && !flush) if_rdata = mem_rdata;
         end
         default: ;
      endcase
   end

   assign if_stall  = if_req & ~if_valid;
   assign d_stall   = d_req & ~d_valid;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_be    = r_be;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt_d <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (w_grant) begin
         r_gnt_d <= w_grant_d;
         r_we    <= w_grant_d & d_we;
         r_addr  <= w_grant_d ? d_addr : if_addr;
         r_wdata <= (w_grant_d & d_we) ? d_wdata : '0;
         r_be    <= (w_grant_d & d_we) ? d_be : {BE_W{1'b1}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_cnt <= 3'(MEM_LAT - 1);
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_drop <= 1'b0;
      end else if (flush && !w_idle && !r_gnt_d) begin
         r_drop <= 1'b1;
      end
   end

   // Streak only counts data wins that actually made a fetch wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_streak <= '0;
      end else if (w_idle) begin
         if (!if_req || w_grant_i)            r_streak <= '0;
         else if (w_grant_d && !w_streak_full) r_streak <= r_streak + 4'd1;
      end
   end

   a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (d_req & ~d_valid) |=> d_req);
   a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (if_req & ~if_valid & ~flush) |=> if_req);

endmodule
